// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
//
// Machine-mode control/status register file for a small RISC-V style core.
// Holds mstatus (MIE/MPIE only), mtvec, mscratch, mepc, mcause, mtval and
// the 64-bit mcycle/minstret counters with their read-only user shadows.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   csr_en         a CSR instruction is presented this cycle
//   csr_op         00 no-op, 01 RW, 10 RS (set bits), 11 RC (clear bits)
//   csr_addr       12-bit CSR address
//   csr_wdata      source operand of the CSR instruction
//   csr_rdata      current (pre-update) value of the addressed CSR
//   csr_illegal    access faults: unknown address or write to read-only CSR
//   instr_retire   one instruction retires this cycle (minstret increment)
//   trap_en        trap entry request
//   trap_pc        pc of the trapping instruction (stored into mepc)
//   trap_cause     trap cause (stored into mcause)
//   trap_val       trap value (stored into mtval)
//   mret_en        MRET executed this cycle
//   trap_vector    current mtvec
//   mepc_out       current mepc
//   mie_out        current mstatus.MIE
// ---------------------------------------------------------------------------
module csr_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
    parameter int              HAS_COUNTERS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_val,
    input  logic            mret_en,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            mie_out
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam bit CNT_EN = (HAS_COUNTERS != 0);
    localparam bit RV32   = (XLEN == 32);

    // mtvec and mepc are always word aligned (direct vectoring only).
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] MTVEC_INIT = MTVEC_RESET & ALIGN_MASK;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            mie_q,      mie_d;
    logic            mpie_q,     mpie_d;
    logic [XLEN-1:0] mtvec_q,    mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q,     mepc_d;
    logic [XLEN-1:0] mcause_q,   mcause_d;
    logic [XLEN-1:0] mtval_q,    mtval_d;

    // Counter index 0 = mcycle, 1 = minstret.
    logic [63:0]     cnt_val [2];
    logic [1:0]      cnt_inc;
    logic [1:0]      cnt_we_lo;
    logic [1:0]      cnt_we_hi;

    // ------------------------------------------------------------------
    // Read decode
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mstatus_view;
    logic [XLEN-1:0] rdata_sel;
    logic            addr_impl;
    logic            write_req;
    logic            csr_we;
    logic [XLEN-1:0] new_val;

    always_comb begin
        mstatus_view    = '0;
        mstatus_view[3] = mie_q;
        mstatus_view[7] = mpie_q;
    end

    always_comb begin
        addr_impl = 1'b0;
        rdata_sel = '0;
        case (csr_addr)
            ADDR_MSTATUS: begin
                addr_impl = 1'b1;
                rdata_sel = mstatus_view;
            end
            ADDR_MTVEC: begin
                addr_impl = 1'b1;
                rdata_sel = mtvec_q;
            end
            ADDR_MSCRATCH: begin
                addr_impl = 1'b1;
                rdata_sel = mscratch_q;
            end
            ADDR_MEPC: begin
                addr_impl = 1'b1;
                rdata_sel = mepc_q;
            end
            ADDR_MCAUSE: begin
                addr_impl = 1'b1;
                rdata_sel = mcause_q;
            end
            ADDR_MTVAL: begin
                addr_impl = 1'b1;
                rdata_sel = mtval_q;
            end
            ADDR_MCYCLE, ADDR_CYCLE: begin
                addr_impl = CNT_EN;
                rdata_sel = cnt_val[0][XLEN-1:0];
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                addr_impl = CNT_EN;
                rdata_sel = cnt_val[1][XLEN-1:0];
            end
            // Upper halves only exist as separate CSRs on a 32-bit machine.
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                addr_impl = CNT_EN && RV32;
                rdata_sel = XLEN'(cnt_val[0][63:32]);
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                addr_impl = CNT_EN && RV32;
                rdata_sel = XLEN'(cnt_val[1][63:32]);
            end
            default: begin
                addr_impl = 1'b0;
                rdata_sel = '0;
            end
        endcase
    end

    assign csr_rdata = addr_impl ? rdata_sel : '0;

    // RS/RC with a zero operand are pure reads, so they may target the
    // read-only 0xCxx block without faulting.
    assign write_req = (csr_op == OP_RW) ||
                       (((csr_op == OP_RS) || (csr_op == OP_RC)) && (|csr_wdata));

    assign csr_illegal = csr_en &&
                         (!addr_impl || (write_req && (csr_addr[11:10] == 2'b11)));

    assign csr_we = csr_en && !csr_illegal && write_req;

    always_comb begin
        new_val = csr_rdata;
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = csr_rdata | csr_wdata;
            OP_RC:   new_val = csr_rdata & ~csr_wdata;
            OP_NOP:  new_val = csr_rdata;
            default: new_val = csr_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Write strobes
    // ------------------------------------------------------------------
    logic we_mstatus, we_mtvec, we_mscratch, we_mepc, we_mcause, we_mtval;

    assign we_mstatus  = csr_we && (csr_addr == ADDR_MSTATUS);
    assign we_mtvec    = csr_we && (csr_addr == ADDR_MTVEC);
    assign we_mscratch = csr_we && (csr_addr == ADDR_MSCRATCH);
    assign we_mepc     = csr_we && (csr_addr == ADDR_MEPC);
    assign we_mcause   = csr_we && (csr_addr == ADDR_MCAUSE);
    assign we_mtval    = csr_we && (csr_addr == ADDR_MTVAL);

    assign cnt_we_lo = {csr_we && (csr_addr == ADDR_MINSTRET),
                        csr_we && (csr_addr == ADDR_MCYCLE)};
    assign cnt_we_hi = {csr_we && (csr_addr == ADDR_MINSTRETH),
                        csr_we && (csr_addr == ADDR_MCYCLEH)};
    assign cnt_inc   = {instr_retire, 1'b1};

    // ------------------------------------------------------------------
    // Trap / MRET / CSR-write next state
    // Trap entry beats MRET, which beats a software write, but only for
    // the registers each of them touches.
    // ------------------------------------------------------------------
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;

        if (we_mtvec) begin
            mtvec_d = new_val & ALIGN_MASK;
        end
        if (we_mscratch) begin
            mscratch_d = new_val;
        end

        if (trap_en) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (mret_en) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (we_mstatus) begin
            mie_d  = new_val[3];
            mpie_d = new_val[7];
        end

        if (trap_en) begin
            mepc_d   = trap_pc & ALIGN_MASK;
            mcause_d = trap_cause;
            mtval_d  = trap_val;
        end else begin
            if (we_mepc) begin
                mepc_d = new_val & ALIGN_MASK;
            end
            if (we_mcause) begin
                mcause_d = new_val;
            end
            if (we_mtval) begin
                mtval_d = new_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_INIT;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    // ------------------------------------------------------------------
    // 64-bit counters. An explicit write to either half replaces that half
    // and holds the counter for the cycle instead of incrementing it.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_counter
            logic [63:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_we_lo[gi]) begin
                    cnt_d = RV32 ? {cnt_q[63:32], new_val[31:0]} : 64'(new_val);
                end else if (cnt_we_hi[gi]) begin
                    cnt_d = {new_val[31:0], cnt_q[31:0]};
                end else if (CNT_EN && cnt_inc[gi]) begin
                    cnt_d = cnt_q + 64'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_val[gi] = cnt_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Direct register outputs
    // ------------------------------------------------------------------
    assign trap_vector = mtvec_q;
    assign mepc_out    = mepc_q;
    assign mie_out     = mie_q;

endmodule

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
//
// Scoreboard bench for csr_unit (XLEN=32). The driver applies one cycle of
// stimulus at each falling edge, asks a behavioural model what the DUT must
// show for that cycle, queues that expectation and then advances the model
// to the state after the next rising edge. An independent monitor samples the
// DUT shortly after each falling edge whenever csr_en is high and compares it
// with the head of the queue.
// ---------------------------------------------------------------------------
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_1003;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        mret_en;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        mie_out;

    csr_unit #(
        .XLEN         (32),
        .MTVEC_RESET  (MTVEC_RST),
        .HAS_COUNTERS (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .csr_en       (csr_en),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .instr_retire (instr_retire),
        .trap_en      (trap_en),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .trap_val     (trap_val),
        .mret_en      (mret_en),
        .trap_vector  (trap_vector),
        .mepc_out     (mepc_out),
        .mie_out      (mie_out)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] rdata;
        logic        ill;
        logic [31:0] tvec;
        logic [31:0] mepc;
        logic        mie;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [11:0] a,
                                  input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s addr=%h got=%h expected=%h", name, a, act, req);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (csr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", csr_addr, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("txn op=%0d addr=%h rdata=%h ill=%0b tvec=%h mepc=%h mie=%0b",
                         e.op, e.addr, csr_rdata, csr_illegal, trap_vector, mepc_out, mie_out);
                check("rdata",       e.addr, csr_rdata,          e.rdata);
                check("illegal",     e.addr, {31'd0, csr_illegal}, {31'd0, e.ill});
                check("trap_vector", e.addr, trap_vector,        e.tvec);
                check("mepc_out",    e.addr, mepc_out,           e.mepc);
                check("mie_out",     e.addr, {31'd0, mie_out},   {31'd0, e.mie});
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model: named CSRs in an associative array, mstatus as two
    // flag bits, counters as plain 64-bit integers.
    // ------------------------------------------------------------------
    logic        m_mie, m_mpie;
    logic [31:0] m_csr [logic [11:0]];
    logic [63:0] m_cyc, m_ins;

    function automatic void model_reset();
        m_mie  = 1'b0;
        m_mpie = 1'b0;
        m_csr[12'h305] = MTVEC_RST & 32'hFFFF_FFFC;
        m_csr[12'h340] = 32'd0;
        m_csr[12'h341] = 32'd0;
        m_csr[12'h342] = 32'd0;
        m_csr[12'h343] = 32'd0;
        m_cyc = 64'd0;
        m_ins = 64'd0;
    endfunction

    function automatic logic model_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                         12'hB00, 12'hB02, 12'hB80, 12'hB82,
                         12'hC00, 12'hC02, 12'hC80, 12'hC82};
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300:                            return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
            12'h305, 12'h340, 12'h341,
            12'h342, 12'h343:                   return m_csr[a];
            12'hB00, 12'hC00:                   return m_cyc[31:0];
            12'hB80, 12'hC80:                   return m_cyc[63:32];
            12'hB02, 12'hC02:                   return m_ins[31:0];
            12'hB82, 12'hC82:                   return m_ins[63:32];
            default:                            return 32'd0;
        endcase
    endfunction

    // One clock cycle of stimulus; model advanced to the post-edge state.
    task automatic cyc(input logic rst, input logic en, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd, input logic ret,
                       input logic trap, input logic [31:0] pc, input logic [31:0] cause,
                       input logic [31:0] tval, input logic mret);
        exp_t        e;
        logic [31:0] old, nv;
        logic        ill, wr_try, old_mie, old_mpie;
        logic [63:0] cyc0, ins0;
        @(negedge clk);
        rst_n        = rst;
        csr_en       = en;
        csr_op       = op;
        csr_addr     = a;
        csr_wdata    = wd;
        instr_retire = ret;
        trap_en      = trap;
        trap_pc      = pc;
        trap_cause   = cause;
        trap_val     = tval;
        mret_en      = mret;

        if (!rst) model_reset();
        old    = model_read(a);
        wr_try = (op == 2'b01) || ((op != 2'b00) && (wd != 32'd0));
        ill    = !model_impl(a) || (wr_try && (a[11:10] == 2'b11));
        if (en) begin
            e.addr  = a;
            e.op    = op;
            e.rdata = old;
            e.ill   = ill;
            e.tvec  = m_csr[12'h305];
            e.mepc  = m_csr[12'h341];
            e.mie   = m_mie;
            exp_q.push_back(e);
        end

        if (rst) begin
            old_mie  = m_mie;
            old_mpie = m_mpie;
            cyc0     = m_cyc;
            ins0     = m_ins;
            m_cyc    = m_cyc + 64'd1;
            if (ret) m_ins = m_ins + 64'd1;
            if (en && !ill && wr_try) begin
                if (op == 2'b01)      nv = wd;
                else if (op == 2'b10) nv = old | wd;
                else                  nv = old & ~wd;
                case (a)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305, 12'h341: m_csr[a] = nv & 32'hFFFF_FFFC;
                    12'h340, 12'h342, 12'h343: m_csr[a] = nv;
                    12'hB00: m_cyc = {cyc0[63:32], nv};
                    12'hB80: m_cyc = {nv, cyc0[31:0]};
                    12'hB02: m_ins = {ins0[63:32], nv};
                    12'hB82: m_ins = {nv, ins0[31:0]};
                    default: ;
                endcase
            end
            // Later assignments override earlier ones: trap > mret > write.
            if (mret) begin
                m_mie  = old_mpie;
                m_mpie = 1'b1;
            end
            if (trap) begin
                m_mpie = old_mie;
                m_mie  = 1'b0;
                m_csr[12'h341] = pc & 32'hFFFF_FFFC;
                m_csr[12'h342] = cause;
                m_csr[12'h343] = tval;
            end
        end
    endtask

    task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        cyc(1'b1, 1'b1, op, a, wd, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [11:0] a);
        acc(2'b10, a, 32'd0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 2'b00, 12'h000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [11:0] addr_pool [18] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                    12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                    12'hC80, 12'hC82, 12'h7C0, 12'h301, 12'h344, 12'hF11};

    initial begin
        logic [11:0] ra;
        logic [31:0] rw;
        logic [1:0]  rop;
        logic        ren, rret, rtrap, rmret;

        rst_n = 1'b1; csr_en = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
        instr_retire = 1'b0; trap_en = 1'b0; trap_pc = '0; trap_cause = '0;
        trap_val = '0; mret_en = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();

        // Reset state, then release reset
        cyc(1'b0, 1'b1, 2'b10, 12'h305, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 12'h7C0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 12'hB00, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        rd(12'hB00);

        // mscratch RW / RS / RC
        acc(2'b01, 12'h340, 32'hDEAD_BEEF);
        acc(2'b10, 12'h340, 32'h0000_000F);
        acc(2'b11, 12'h340, 32'hF000_0000);
        rd(12'h340);

        // Illegal accesses and read-only shadow reads
        acc(2'b01, 12'hC00, 32'h1234_5678);
        acc(2'b10, 12'h7C0, 32'd0);
        acc(2'b01, 12'h7C0, 32'h5);
        acc(2'b10, 12'hC00, 32'd0);
        acc(2'b11, 12'hC82, 32'd0);

        // mcycle carry into the high half; minstret counting
        acc(2'b01, 12'hB00, 32'hFFFF_FFFE);
        acc(2'b01, 12'hB80, 32'h0000_0000);
        idle();
        idle();
        rd(12'hB00);
        rd(12'hB80);
        cyc(1'b1, 1'b1, 2'b10, 12'hB02, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        rd(12'hC02);

        // Alignment of mtvec / mepc writes
        acc(2'b01, 12'h305, 32'h8000_0107);
        acc(2'b01, 12'h341, 32'h0000_0333);
        rd(12'h341);

        // Trap and mepc write in the same cycle: trap wins
        cyc(1'b1, 1'b1, 2'b01, 12'h341, 32'h0000_0200, 1'b0, 1'b1,
            32'h0000_0446, 32'h0000_0002, 32'h0000_0011, 1'b0);
        rd(12'h341);
        rd(12'h343);

        // MIE set, trap entry, MRET
        acc(2'b10, 12'h300, 32'h0000_0008);
        cyc(1'b1, 1'b1, 2'b10, 12'h300, 32'd0, 1'b0, 1'b1,
            32'h0000_0103, 32'h0000_000B, 32'hCAFE_0000, 1'b0);
        rd(12'h300);
        rd(12'h342);
        cyc(1'b1, 1'b1, 2'b10, 12'h341, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
        rd(12'h300);

        // Reset pulse mid-sequence: outputs must drop before the next edge
        cyc(1'b0, 1'b1, 2'b10, 12'h341, 32'd0, 1'b1, 1'b1,
            32'h0000_0777, 32'h1, 32'h2, 1'b0);
        cyc(1'b0, 1'b1, 2'b10, 12'h300, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b1, 2'b10, 12'hB00, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
        rd(12'hB00);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            ra    = addr_pool[$urandom_range(0, 17)];
            rop   = 2'($urandom_range(1, 3));
            rw    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            ren   = ($urandom_range(0, 9) != 0);
            rret  = ($urandom_range(0, 1) == 1);
            rtrap = ($urandom_range(0, 19) == 0);
            rmret = ($urandom_range(0, 14) == 0);
            cyc(1'b1, ren, rop, ra, rw, rret, rtrap, $urandom(), $urandom(), $urandom(), rmret);
        end

        idle();
        idle();
        check("scoreboard_drained", 12'h000, 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width (32 or 64).
REQ-002 SHALL have parameter MTVEC_RESET, default 0, meaning mtvec value after reset.
REQ-003 SHALL have parameter HAS_COUNTERS, default 1, meaning cycle/instret counters present (0: those addresses illegal).
REQ-004 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port csr_en  in  1  CSR instruction valid this cycle.
REQ-007 SHALL have port csr_op  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 no-op.
REQ-008 SHALL have ports csr_addr  in  12 and csr_wdata  in  XLEN  CSR address and source operand.
REQ-009 SHALL have ports csr_rdata  out  XLEN and csr_illegal  out  1  old CSR value (combinational) and illegal-access flag.
REQ-010 SHALL have port instr_retire  in  1  one instruction retired this cycle.
REQ-011 SHALL have ports trap_en  in  1, trap_pc/trap_cause/trap_val  in  XLEN each  trap entry request and its data.
REQ-012 SHALL have port mret_en  in  1  MRET executed.
REQ-013 SHALL have ports trap_vector, mepc_out  out  XLEN and mie_out  out  1  mtvec, mepc and mstatus.MIE.

Function
REQ-014 SHALL implement mstatus 0x300 (MIE bit 3, MPIE bit 7 writable; other bits read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
REQ-015 SHALL implement 64-bit mcycle/minstret: 0xB00/0xB02 = low XLEN bits; when XLEN=32, 0xB80/0xB82 = high 32 bits; read-only shadows 0xC00/0xC02 (and 0xC80/0xC82 when XLEN=32).
REQ-016 SHALL compute new value: RW = wdata; RS = old | wdata; RC = old & ~wdata; committed on next posedge when csr_en && !csr_illegal && op != 00.
REQ-017 SHALL treat RS/RC with csr_wdata == 0 as read-only: no write, not illegal on read-only CSRs.
REQ-018 SHALL assert csr_illegal (combinational) for unimplemented address, or write attempt (RW, or RS/RC with nonzero wdata) to csr_addr[11:10] == 2'b11; csr_rdata = 0 for unimplemented addresses; no state change.
REQ-019 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write (direct mode, aligned).
REQ-020 SHALL increment mcycle every cycle out of reset and minstret when instr_retire = 1; both wrap 2^64-1 -> 0.
REQ-021 SHALL, on an explicit write to any counter half, store the written half, leave the other half unchanged, and suppress that counter's increment that cycle.
REQ-022 SHALL on trap_en: mepc <= trap_pc & ~3, mcause <= trap_cause, mtval <= trap_val, MPIE <= MIE, MIE <= 0.
REQ-023 SHALL on mret_en (trap_en low): MIE <= MPIE, MPIE <= 1.
REQ-024 SHALL apply priority trap_en > mret_en > CSR write for the same CSR in one cycle; the lower-priority update to an overlapped CSR is dropped, non-overlapping updates still take effect; counters still increment.
REQ-025 SHALL drive trap_vector = mtvec, mepc_out = mepc, mie_out = mstatus[3] directly from registers (no added latency); csr_rdata shows pre-update value in the same cycle.

Reset
REQ-026 SHALL, while rst_n = 0, immediately clear all CSRs and counters to 0 except mtvec = MTVEC_RESET & ~3; hence trap_vector = MTVEC_RESET & ~3, mepc_out = 0, mie_out = 0, csr_illegal per address only.
REQ-027 SHALL abandon any in-flight write or trap on reset assertion; first mcycle increment on first posedge after rst_n rises.

Verification
REQ-028 SHALL cover: RW 0x340 wdata 0xDEADBEEF, then RS 0x0000000F, then RC 0xF0000000 -> reads 0xDEADBEEF, then 0x0DEADBEEF-or-F = 0xDEADBEEF, then 0x0EADBEEF.
REQ-029 SHALL cover: MIE set, trap_en with pc 0x00000103, cause 0x0000000B -> mepc_out 0x00000100, mcause 0xB, mie_out 0, MPIE 1; then mret_en -> mie_out 1.
REQ-030 SHALL cover: XLEN=32, write mcycle 0xFFFFFFFE, mcycleh 0 -> after 2 cycles low 0x00000000, mcycleh 0x00000001.
REQ-031 SHALL cover: RW to 0xC00, and any access to 0x7C0 -> csr_illegal 1, no state change; RS 0xC00 wdata 0 -> csr_illegal 0, returns count.
REQ-032 SHALL cover: trap_en and RW mepc 0x200 same cycle -> mepc = trap_pc; rst_n pulsed low mid-sequence -> outputs at reset values before next posedge.
